vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 152 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel divider, h/v counters, registered sync/active/strobe outputs.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output (Snake speed timebase).
module vga_timing_gen #(
    parameter int PIX_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       en,
    output logic       pix_ce,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: PIX_DIV must be 1..16");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: totals do not fit the 10-bit counters");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic             tick, tick_q, tick_d;

    logic       pix_ce_q, pix_ce_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic       line_start_q, line_start_d, frame_start_q, frame_start_d;

    always_comb begin
        tick   = en && (div_q == DIV_MAX);
        tick_d = tick;
        div_d  = div_q;
        h_d    = h_q;
        v_d    = v_q;
        if (en) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        end
        if (tick) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Outputs sample the counters one ACLK after they move, so pix_ce lines up with the new x/y.
    always_comb begin
        pix_ce_d      = tick_q;
        x_d           = h_q;
        y_d           = v_q;
        active_d      = (h_q < H_ACT) && (v_q < V_ACT);
        hsync_d       = (h_q >= HS_FIRST && h_q <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (v_q >= VS_FIRST && v_q <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        line_start_d  = tick_q && (h_q == 10'd0);
        frame_start_d = line_start_d && (v_q == 10'd0);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            tick_q        <= 1'b0;
            pix_ce_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            tick_q        <= tick_d;
            pix_ce_q      <= pix_ce_d;
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Steps together with frame_start so both are visible in the same ACLK.
    always_comb begin
        frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so whole frames fit in a short run.
// Reference model derives h/v from the count of enabled cycles with plain division.
module tb_vga_timing_gen;

    localparam int PD  = 3;
    localparam int HA  = 20;
    localparam int HFP = 3;
    localparam int HS  = 5;
    localparam int HB  = 4;
    localparam int VA  = 6;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int HT  = HA + HFP + HS + HB;
    localparam int VT  = VA + VFP + VS + VB;
    localparam bit POL = 1'b0;
    localparam int LIM = HT * VT * PD * 2 + 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       pix_ce, active, hsync, vsync, line_start, frame_start;
    logic [9:0] x, y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] exp_fc;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
    ) dut (
        .ACLK(clk), .ARESET(rst), .en(en),
        .pix_ce(pix_ce), .x(x), .y(y), .active(active),
        .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    // ---------------- reference model ----------------
    int unsigned n_en;
    bit          prev_tick;
    bit          mvalid = 1'b0;
    logic [25:0] exp_vec;
    wire  [25:0] act_vec = {pix_ce, x, y, active, hsync, vsync, line_start, frame_start};

    function automatic logic [25:0] expect_from(input int unsigned n, input bit pce);
        int unsigned p;
        int h, v;
        bit act, hs, vs, ls, fs;
        p   = (n / PD) % (HT * VT);
        h   = int'(p % HT);
        v   = int'(p / HT);
        act = (h < HA) && (v < VA);
        hs  = (h >= HA + HFP && h < HA + HFP + HS) ? POL : !POL;
        vs  = (v >= VA + VFP && v < VA + VFP + VS) ? POL : !POL;
        ls  = pce && (h == 0);
        fs  = ls && (v == 0);
        return {pce, 10'(h), 10'(v), act, hs, vs, ls, fs};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n_en      = 0;
            prev_tick = 1'b0;
            exp_vec   = {1'b0, 10'd0, 10'd0, 1'b0, !POL, !POL, 1'b0, 1'b0};
            mvalid    = 1'b1;
`ifdef VGA_TIMING_FRAME_CNT_EN
            exp_fc    = 16'd0;
`endif
        end else begin
            exp_vec   = expect_from(n_en, prev_tick);
            prev_tick = en && ((n_en % PD) == PD - 1);
            if (en) n_en++;
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (exp_vec[0]) exp_fc = exp_fc + 16'd1;
`endif
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            n_chk++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL model t=%0t got {pce,x,y,act,hs,vs,ls,fs}=%b_%0d_%0d_%b%b%b%b%b want %b_%0d_%0d_%b%b%b%b%b",
                         $time, act_vec[25], act_vec[24:15], act_vec[14:5], act_vec[4], act_vec[3],
                         act_vec[2], act_vec[1], act_vec[0], exp_vec[25], exp_vec[24:15],
                         exp_vec[14:5], exp_vec[4], exp_vec[3], exp_vec[2], exp_vec[1], exp_vec[0]);
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            n_chk++;
            if (frame_cnt !== exp_fc) begin
                n_fail++;
                $display("FAIL frame_cnt got %0d want %0d", frame_cnt, exp_fc);
            end
`endif
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic wait_pix_x(input int xv, input string tag);
        int c;
        c = 0;
        while (!(pix_ce === 1'b1 && x == 10'(xv)) && c < LIM) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_timeout"}, (c < LIM) ? 1 : 0, 1);
    endtask

    task automatic wait_frame(input string tag);
        int c;
        c = 0;
        while (frame_start !== 1'b1 && c < LIM) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_timeout"}, (c < LIM) ? 1 : 0, 1);
    endtask

    typedef struct {
        bit rst;
        bit en;
        bit pce;
        int x;
        bit act;
        bit hs;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int cyc, ls_cnt, hs_cnt, vs_cnt, hs_min, hs_max;

        // {rst, en, pix_ce, x, active, hsync} -- outputs one ACLK after the inputs
        tbl[0]  = '{1, 1, 0, 0, 0, 1};
        tbl[1]  = '{0, 1, 0, 0, 1, 1};
        tbl[2]  = '{0, 1, 0, 0, 1, 1};
        tbl[3]  = '{0, 1, 0, 0, 1, 1};
        tbl[4]  = '{0, 1, 1, 1, 1, 1};
        tbl[5]  = '{0, 0, 0, 1, 1, 1};
        tbl[6]  = '{0, 0, 0, 1, 1, 1};
        tbl[7]  = '{0, 1, 0, 1, 1, 1};
        tbl[8]  = '{0, 1, 0, 1, 1, 1};
        tbl[9]  = '{0, 1, 1, 2, 1, 1};
        tbl[10] = '{0, 1, 0, 2, 1, 1};

        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            @(negedge clk);
            n_chk++;
            if ({pix_ce, x, active, hsync} !== {tbl[i].pce, 10'(tbl[i].x), tbl[i].act, tbl[i].hs}) begin
                n_fail++;
                $display("FAIL table[%0d] got pce=%b x=%0d act=%b hs=%b want pce=%b x=%0d act=%b hs=%b",
                         i, pix_ce, x, active, hsync, tbl[i].pce, tbl[i].x, tbl[i].act, tbl[i].hs);
            end
        end

        // Whole-frame statistics between two frame_starts.
        en = 1'b1;
        wait_frame("frame_first");
        cyc = 0; ls_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs_min = 1023; hs_max = -1;
        for (int c = 0; c < LIM; c++) begin
            if (line_start === 1'b1) ls_cnt++;
            if (pix_ce === 1'b1 && hsync === POL) begin
                hs_cnt++;
                if (int'(x) < hs_min) hs_min = int'(x);
                if (int'(x) > hs_max) hs_max = int'(x);
            end
            if (pix_ce === 1'b1 && vsync === POL) vs_cnt++;
            @(negedge clk);
            cyc++;
            if (frame_start === 1'b1) break;
        end
        check("frame_period", cyc, HT * VT * PD);
        check("lines_per_frame", ls_cnt, VT);
        check("hsync_strobes", hs_cnt, HS * VT);
        check("hsync_first_x", hs_min, HA + HFP);
        check("hsync_last_x", hs_max, HA + HFP + HS - 1);
        check("vsync_strobes", vs_cnt, VS * HT);

        // en held low mid-line.
        wait_pix_x(5, "hold_entry");
        en = 1'b0;
        for (int c = 0; c < 37; c++) begin
            @(negedge clk);
            check("hold_x", int'(x), 5);
            check("hold_pix_ce", int'(pix_ce), 0);
        end
        en = 1'b1;
        @(negedge clk);
        while (pix_ce !== 1'b1 && cyc < LIM) begin
            @(negedge clk);
            cyc++;
        end
        check("resume_x", int'(x), 6);

        // Single-cycle reset inside hsync.
        wait_pix_x(HA + HFP + 2, "rst_entry");
        check("rst_in_hsync", int'(hsync), int'(POL));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_hsync", int'(hsync), int'(!POL));
        check("rst_active", int'(active), 0);
        check("rst_pix_ce", int'(pix_ce), 0);
        @(negedge clk);
        check("post_rst_active", int'(active), 1);
        check("post_rst_x", int'(x), 0);
        wait_pix_x(1, "post_rst_first_pix");
        check("post_rst_first_y", int'(y), 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 3; f++) begin
            @(negedge clk);
            wait_frame("fc_frame");
        end
        check("frame_cnt_3", int'(frame_cnt), 3);
`endif

        // Randomised en and occasional reset, checked cycle by cycle by the model.
        for (int c = 0; c < 6000; c++) begin
            en  = ($urandom % 4) != 0;
            rst = ($urandom % 700) == 0;
            @(negedge clk);
        end
        rst = 1'b0;
        en  = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
